// File: rtl/rv_pkg.sv
// Shared fetch-path definitions: datapath width, reset vector, NOP encoding and the FIFO entry layout.
package rv_pkg;

  localparam int unsigned XLEN     = 32;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] INST_NOP = 32'h0000_0013;
  localparam int unsigned ENTRY_W  = XLEN + 32;

  // PC sits above the instruction word so {pc, inst} concatenations line up with this struct.
  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [31:0]     inst;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous prefetch FIFO; read data is combinational from the head slot.
// flush wins over push/pop in the same cycle.
module fetch_fifo #(
  parameter int unsigned WIDTH = rv_pkg::ENTRY_W,
  parameter int unsigned DEPTH = 2
) (
  input  logic                   clock_i,
  input  logic                   reset_i,
  input  logic                   push_i,
  input  logic                   pop_i,
  input  logic                   flush_i,
  input  logic [WIDTH-1:0]       wdata_i,
  output logic [WIDTH-1:0]       rdata_o,
  output logic                   empty_o,
  output logic                   full_o,
  output logic [$clog2(DEPTH):0] count_o
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             do_push, do_pop;

  assign do_push = push_i & ~flush_i;
  assign do_pop  = pop_i & ~flush_i & ~empty_o;

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      count_d = count_q + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
    end
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset; only slots behind a valid count are ever presented.
  always_ff @(posedge clock_i) begin
    if (!reset_i && do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

  always_ff @(posedge clock_i) begin
    if (!reset_i && do_push) assert (!full_o);
  end

  assign rdata_o = mem_q[rd_ptr_q];
  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == (AW + 1)'(DEPTH));
  assign count_o = count_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: owns the PC, issues 1-cycle-latency imem reads under a credit limit and
// buffers {pc, inst} for decode; execute redirects flush buffered and in-flight fetches.
module fetch_stage
  import rv_pkg::*;
#(
  parameter int unsigned XLEN       = rv_pkg::XLEN,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(rv_pkg::RESET_PC),
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic            clock_i,
  input  logic            reset_i,
  output logic            imem_req_o,
  output logic [XLEN-1:0] imem_addr_o,
  input  logic [31:0]     imem_rdata_i,
  input  logic            redirect_valid_i,
  input  logic [XLEN-1:0] redirect_pc_i,
  output logic            inst_valid_o,
  input  logic            inst_ready_i,
  output logic [31:0]     inst_o,
  output logic [XLEN-1:0] inst_pc_o
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = AW + 2;
  localparam int unsigned EW = XLEN + 32;

  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic [XLEN-1:0] inflight_pc_q, inflight_pc_d;
  logic            inflight_q, inflight_d;
  logic            squash_q, squash_d;

  logic            fifo_empty, fifo_full;
  logic [AW:0]     fifo_count;
  logic [EW-1:0]   fifo_rdata;
  logic            pop, push, issue, credit_ok;

  assign inst_valid_o = ~reset_i & ~redirect_valid_i & ~fifo_empty;
  assign pop          = inst_valid_o & inst_ready_i;

  // Entries already buffered plus the one returning must fit once this cycle's pop leaves.
  assign credit_ok = ({1'b0, fifo_count} + CW'(inflight_q) - CW'(pop)) < CW'(FIFO_DEPTH);
  assign issue     = ~reset_i & ~redirect_valid_i & credit_ok;
  assign push      = inflight_q & ~squash_q;

  assign imem_req_o  = issue;
  assign imem_addr_o = fetch_pc_q;

  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    inflight_pc_d = inflight_pc_q;
    inflight_d    = issue;
    squash_d      = redirect_valid_i;
    if (issue) begin
      fetch_pc_d    = fetch_pc_q + XLEN'(4);
      inflight_pc_d = fetch_pc_q;
    end
    if (redirect_valid_i) fetch_pc_d = {redirect_pc_i[XLEN-1:2], 2'b00};
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      fetch_pc_q    <= RESET_PC;
      inflight_pc_q <= RESET_PC;
      inflight_q    <= 1'b0;
      squash_q      <= 1'b0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      inflight_pc_q <= inflight_pc_d;
      inflight_q    <= inflight_d;
      squash_q      <= squash_d;
    end
  end

  fetch_fifo #(
    .WIDTH (EW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clock_i (clock_i),
    .reset_i (reset_i),
    .push_i  (push),
    .pop_i   (pop),
    .flush_i (redirect_valid_i),
    .wdata_i ({inflight_pc_q, imem_rdata_i}),
    .rdata_o (fifo_rdata),
    .empty_o (fifo_empty),
    .full_o  (fifo_full),
    .count_o (fifo_count)
  );

  assign {inst_pc_o, inst_o} = fifo_rdata;

  logic unused_full;
  assign unused_full = fifo_full;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: a 1-cycle memory model returns addr|0x13 for every request.
module tb_fetch_stage;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, redir, rdy, req, vld;
  logic [31:0] redir_pc, addr, rdata, inst, ipc;
  logic        rst2, req2, vld2;
  logic [31:0] addr2, rdata2, inst2, ipc2;

  int n_cmp = 0;
  int n_bad = 0;

  fetch_stage dut (
    .clock_i(clk), .reset_i(rst), .imem_req_o(req), .imem_addr_o(addr), .imem_rdata_i(rdata),
    .redirect_valid_i(redir), .redirect_pc_i(redir_pc), .inst_valid_o(vld),
    .inst_ready_i(rdy), .inst_o(inst), .inst_pc_o(ipc)
  );

  fetch_stage #(.RESET_PC(32'hFFFF_FFF8)) dut_wrap (
    .clock_i(clk), .reset_i(rst2), .imem_req_o(req2), .imem_addr_o(addr2), .imem_rdata_i(rdata2),
    .redirect_valid_i(1'b0), .redirect_pc_i(32'h0), .inst_valid_o(vld2),
    .inst_ready_i(1'b1), .inst_o(inst2), .inst_pc_o(ipc2)
  );

  always @(posedge clk) begin
    rdata  <= req  ? (addr  | 32'h13) : 32'hDEAD_BEEF;
    rdata2 <= req2 ? (addr2 | 32'h13) : 32'hDEAD_BEEF;
  end

  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; redir = 1'b0; redir_pc = 32'h0; rdy = 1'b1;
    next_cyc();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; redir = 1'b1; redir_pc = 32'h40; rdy = 1'b1;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      n_cmp++; if (req !== 1'b0) begin n_bad++; $display("FAIL reset c%0d imem_req got %b want 0", k, req); end
      n_cmp++; if (vld !== 1'b0) begin n_bad++; $display("FAIL reset c%0d inst_valid got %b want 0", k, vld); end
      next_cyc();
    end
    redir = 1'b0;
    rst = 1'b0;
  endtask

  // Straight-line fetch from RESET_PC with decode always ready.
  task automatic test_stream();
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      n_cmp++; if (req !== 1'b1) begin n_bad++; $display("FAIL stream c%0d imem_req got %b want 1", k, req); end
      n_cmp++; if (addr !== 32'(4 * k)) begin n_bad++; $display("FAIL stream c%0d imem_addr got %h want %h", k, addr, 32'(4 * k)); end
      n_cmp++; if (vld !== (k >= 2)) begin n_bad++; $display("FAIL stream c%0d inst_valid got %b want %b", k, vld, k >= 2); end
      if (k >= 2) begin
        n_cmp++; if (ipc !== 32'(4 * (k - 2))) begin n_bad++; $display("FAIL stream c%0d inst_pc got %h want %h", k, ipc, 32'(4 * (k - 2))); end
        n_cmp++; if (inst !== (32'(4 * (k - 2)) | 32'h13)) begin n_bad++; $display("FAIL stream c%0d inst got %h want %h", k, inst, 32'(4 * (k - 2)) | 32'h13); end
      end
      next_cyc();
    end
  endtask

  task automatic test_stall();
    logic        e_req [10];
    logic [31:0] e_addr[10];
    logic        e_vld [10];
    logic [31:0] e_pc  [10];
    e_req  = '{1, 1, 0, 0, 0, 0, 1, 1, 1, 1};
    e_addr = '{32'h0, 32'h4, 0, 0, 0, 0, 32'h8, 32'hC, 32'h10, 32'h14};
    e_vld  = '{0, 0, 1, 1, 1, 1, 1, 1, 1, 1};
    e_pc   = '{0, 0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h4, 32'h8, 32'hC};
    do_reset();
    for (int k = 0; k < 10; k++) begin
      rdy = !(k >= 2 && k <= 5);
      @(negedge clk);
      n_cmp++; if (req !== e_req[k]) begin n_bad++; $display("FAIL stall c%0d imem_req got %b want %b", k, req, e_req[k]); end
      if (e_req[k]) begin
        n_cmp++; if (addr !== e_addr[k]) begin n_bad++; $display("FAIL stall c%0d imem_addr got %h want %h", k, addr, e_addr[k]); end
      end
      n_cmp++; if (vld !== e_vld[k]) begin n_bad++; $display("FAIL stall c%0d inst_valid got %b want %b", k, vld, e_vld[k]); end
      if (e_vld[k]) begin
        n_cmp++; if (ipc !== e_pc[k]) begin n_bad++; $display("FAIL stall c%0d inst_pc got %h want %h", k, ipc, e_pc[k]); end
        n_cmp++; if (inst !== (e_pc[k] | 32'h13)) begin n_bad++; $display("FAIL stall c%0d inst got %h want %h", k, inst, e_pc[k] | 32'h13); end
      end
      next_cyc();
    end
  endtask

  // Redirect while decode is stalled and the 0x4 response is returning in the same cycle.
  task automatic test_redirect_inflight();
    logic        e_req [7];
    logic [31:0] e_addr[7];
    logic        e_vld [7];
    logic [31:0] e_pc  [7];
    e_req  = '{1, 1, 0, 1, 1, 1, 1};
    e_addr = '{32'h0, 32'h4, 0, 32'h100, 32'h104, 32'h108, 32'h10C};
    e_vld  = '{0, 0, 0, 0, 0, 1, 1};
    e_pc   = '{0, 0, 0, 0, 0, 32'h100, 32'h104};
    do_reset();
    for (int k = 0; k < 7; k++) begin
      rdy      = (k != 2);
      redir    = (k == 2);
      redir_pc = 32'h103;
      @(negedge clk);
      n_cmp++; if (req !== e_req[k]) begin n_bad++; $display("FAIL redir c%0d imem_req got %b want %b", k, req, e_req[k]); end
      if (e_req[k]) begin
        n_cmp++; if (addr !== e_addr[k]) begin n_bad++; $display("FAIL redir c%0d imem_addr got %h want %h", k, addr, e_addr[k]); end
      end
      n_cmp++; if (vld !== e_vld[k]) begin n_bad++; $display("FAIL redir c%0d inst_valid got %b want %b", k, vld, e_vld[k]); end
      if (e_vld[k]) begin
        n_cmp++; if (ipc !== e_pc[k]) begin n_bad++; $display("FAIL redir c%0d inst_pc got %h want %h", k, ipc, e_pc[k]); end
        n_cmp++; if (inst !== (e_pc[k] | 32'h13)) begin n_bad++; $display("FAIL redir c%0d inst got %h want %h", k, inst, e_pc[k] | 32'h13); end
      end
      next_cyc();
    end
    redir = 1'b0;
  endtask

  // Redirect coinciding with a would-be pop, then a second redirect that must win.
  task automatic test_back_to_back_redirect();
    logic        e_req [8];
    logic [31:0] e_addr[8];
    logic        e_vld [8];
    logic [31:0] e_pc  [8];
    e_req  = '{1, 1, 0, 0, 1, 1, 1, 1};
    e_addr = '{32'h0, 32'h4, 0, 0, 32'h200, 32'h204, 32'h208, 32'h20C};
    e_vld  = '{0, 0, 0, 0, 0, 0, 1, 1};
    e_pc   = '{0, 0, 0, 0, 0, 0, 32'h200, 32'h204};
    do_reset();
    for (int k = 0; k < 8; k++) begin
      redir    = (k == 2 || k == 3);
      redir_pc = (k == 2) ? 32'h150 : 32'h200;
      @(negedge clk);
      n_cmp++; if (req !== e_req[k]) begin n_bad++; $display("FAIL b2b c%0d imem_req got %b want %b", k, req, e_req[k]); end
      if (e_req[k]) begin
        n_cmp++; if (addr !== e_addr[k]) begin n_bad++; $display("FAIL b2b c%0d imem_addr got %h want %h", k, addr, e_addr[k]); end
      end
      n_cmp++; if (vld !== e_vld[k]) begin n_bad++; $display("FAIL b2b c%0d inst_valid got %b want %b", k, vld, e_vld[k]); end
      if (e_vld[k]) begin
        n_cmp++; if (ipc !== e_pc[k]) begin n_bad++; $display("FAIL b2b c%0d inst_pc got %h want %h", k, ipc, e_pc[k]); end
        n_cmp++; if (inst !== (e_pc[k] | 32'h13)) begin n_bad++; $display("FAIL b2b c%0d inst got %h want %h", k, inst, e_pc[k] | 32'h13); end
      end
      next_cyc();
    end
    redir = 1'b0;
  endtask

  // Reset lands with 0x0 buffered and 0x4 returning; fetch must restart cleanly at RESET_PC.
  task automatic test_reset_midflight();
    logic        e_req [8];
    logic [31:0] e_addr[8];
    logic        e_vld [8];
    logic [31:0] e_pc  [8];
    e_req  = '{1, 1, 0, 0, 1, 1, 1, 1};
    e_addr = '{32'h0, 32'h4, 0, 0, 32'h0, 32'h4, 32'h8, 32'hC};
    e_vld  = '{0, 0, 0, 0, 0, 0, 1, 1};
    e_pc   = '{0, 0, 0, 0, 0, 0, 32'h0, 32'h4};
    do_reset();
    for (int k = 0; k < 8; k++) begin
      rst = (k == 2 || k == 3);
      rdy = (k != 2);
      @(negedge clk);
      n_cmp++; if (req !== e_req[k]) begin n_bad++; $display("FAIL rstmid c%0d imem_req got %b want %b", k, req, e_req[k]); end
      if (e_req[k]) begin
        n_cmp++; if (addr !== e_addr[k]) begin n_bad++; $display("FAIL rstmid c%0d imem_addr got %h want %h", k, addr, e_addr[k]); end
      end
      n_cmp++; if (vld !== e_vld[k]) begin n_bad++; $display("FAIL rstmid c%0d inst_valid got %b want %b", k, vld, e_vld[k]); end
      if (e_vld[k]) begin
        n_cmp++; if (ipc !== e_pc[k]) begin n_bad++; $display("FAIL rstmid c%0d inst_pc got %h want %h", k, ipc, e_pc[k]); end
        n_cmp++; if (inst !== (e_pc[k] | 32'h13)) begin n_bad++; $display("FAIL rstmid c%0d inst got %h want %h", k, inst, e_pc[k] | 32'h13); end
      end
      next_cyc();
    end
    rst = 1'b0;
  endtask

  task automatic test_pc_wrap();
    logic [31:0] e_addr[5];
    logic [31:0] e_pc  [5];
    e_addr = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0, 32'h4, 32'h8};
    e_pc   = '{0, 0, 32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0};
    rst2 = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      n_cmp++; if (req2 !== 1'b1) begin n_bad++; $display("FAIL wrap c%0d imem_req got %b want 1", k, req2); end
      n_cmp++; if (addr2 !== e_addr[k]) begin n_bad++; $display("FAIL wrap c%0d imem_addr got %h want %h", k, addr2, e_addr[k]); end
      n_cmp++; if (vld2 !== (k >= 2)) begin n_bad++; $display("FAIL wrap c%0d inst_valid got %b want %b", k, vld2, k >= 2); end
      if (k >= 2) begin
        n_cmp++; if (ipc2 !== e_pc[k]) begin n_bad++; $display("FAIL wrap c%0d inst_pc got %h want %h", k, ipc2, e_pc[k]); end
        n_cmp++; if (inst2 !== (e_pc[k] | 32'h13)) begin n_bad++; $display("FAIL wrap c%0d inst got %h want %h", k, inst2, e_pc[k] | 32'h13); end
      end
      next_cyc();
    end
  endtask

  initial begin
    rst = 1'b1; rst2 = 1'b1; redir = 1'b0; redir_pc = 32'h0; rdy = 1'b1;
    next_cyc();
    test_reset();
    test_stream();
    test_stall();
    test_redirect_inflight();
    test_back_to_back_redirect();
    test_reset_midflight();
    test_pc_wrap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
